branch_predict_gshare: RTL and testbench

Parametrised successor to the team's bimodal 2-bit predictor: a gshare direction predictor plus a tagged, valid-qualified branch target buffer (BTB).
- The pattern history table (PHT) of 2-bit saturating counters is indexed by PC XOR global history register (GHR).
- The GHR is updated speculatively at Fetch and repaired from Execute on a mispredict.
- Sits in Fetch, beside the PC mux; trained from Execute.

---
 rtl/bp_pkg.sv | 30 +++
 rtl/bp_btb.sv | 66 ++++++
 rtl/branch_predict_gshare.sv | 151 +++++++++++++++
 tb/tb_branch_predict_gshare.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// Holds the 2-bit saturating counter type, its named states and the
// saturating update used when a branch trains the pattern history table.
package bp_pkg;

   typedef logic [1:0] bp_ctr_t;

   localparam bp_ctr_t CTR_SNT = 2'b00;
   localparam bp_ctr_t CTR_WNT = 2'b01;
   localparam bp_ctr_t CTR_WT  = 2'b10;
   localparam bp_ctr_t CTR_ST  = 2'b11;

   // Step a counter one place towards the resolved outcome, pinning it at
   // the strong ends so a long run of one outcome cannot wrap around.
   function automatic bp_ctr_t bp_sat_update(input bp_ctr_t ctr, input logic taken);
      bp_ctr_t nxt;
      nxt = ctr;
      if (taken) begin
         if (ctr != CTR_ST) begin
            nxt = ctr + 2'b01;
         end
      end else begin
         if (ctr != CTR_SNT) begin
            nxt = ctr - 2'b01;
         end
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped, tagged branch target buffer.
// One combinational lookup port for Fetch and one clocked write port for
// Execute. A lookup in the same cycle as a write to the same entry returns
// the old contents; the write only becomes visible after the clock edge.
module bp_btb #(
   parameter int PC_WIDTH = 32,
   parameter int BTB_BITS = 6,
   parameter int TAG_BITS = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [PC_WIDTH-1:0] rdPc_i,
   output logic                hit_o,
   output logic [PC_WIDTH-1:0] target_o,
   input  logic                we_i,
   input  logic [PC_WIDTH-1:0] wrPc_i,
   input  logic [PC_WIDTH-1:0] wrTarget_i
);

   localparam int ENTRIES = 1 << BTB_BITS;

   logic [ENTRIES-1:0]  valid_q;
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [PC_WIDTH-1:0] target_q [ENTRIES];

   logic [BTB_BITS-1:0] rdIdx;
   logic [TAG_BITS-1:0] rdTag;
   logic [BTB_BITS-1:0] wrIdx;
   logic [TAG_BITS-1:0] wrTag;

   // Only part of each PC forms the index and tag; the rest is
   // folded here so the remaining bits are visibly consumed.
   logic unusedPcBits;
   assign unusedPcBits = ^{rdPc_i, wrPc_i};

   assign rdIdx = rdPc_i[BTB_BITS+1:2];
   assign rdTag = rdPc_i[BTB_BITS+TAG_BITS+1:BTB_BITS+2];
   assign wrIdx = wrPc_i[BTB_BITS+1:2];
   assign wrTag = wrPc_i[BTB_BITS+TAG_BITS+1:BTB_BITS+2];

   // Lookup: an entry hits only when it is valid and its tag matches; a miss
   // drives a zero target so the PC mux never sees stale data.
   always_comb begin
      hit_o    = valid_q[rdIdx] && (tag_q[rdIdx] == rdTag);
      target_o = '0;
      if (hit_o) begin
         target_o = target_q[rdIdx];
      end
   end

   // Write port: a taken branch claims its slot outright, evicting any alias.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
         end
      end else if (we_i) begin
         valid_q[wrIdx]  <= 1'b1;
         tag_q[wrIdx]    <= wrTag;
         target_q[wrIdx] <= wrTarget_i;
      end
   end

endmodule

// File: rtl/branch_predict_gshare.sv
// gshare direction predictor with a tagged BTB, sitting beside the Fetch PC
// mux and trained from Execute. The PHT is indexed by PC XOR global history;
// the history is shifted speculatively on every BTB hit at Fetch and rebuilt
// from the branch's own snapshot when Execute reports a mispredict.
// Optional build macro BP_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_gshare
   import bp_pkg::*;
#(
   parameter int      PC_WIDTH = 32,
   parameter int      PHT_BITS = 10,
   parameter int      GHR_BITS = 8,
   parameter int      BTB_BITS = 6,
   parameter int      TAG_BITS = 8,
   parameter bp_ctr_t CTR_INIT = 2'b01
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [PC_WIDTH-1:0] PCF_i,
   input  logic                fetchValidF_i,
   output logic                predictTakenF_o,
   output logic [PC_WIDTH-1:0] predictTargetF_o,
   output logic [GHR_BITS-1:0] predictGhrF_o,
   input  logic [PC_WIDTH-1:0] PCE_i,
   input  logic                BranchE_i,
   input  logic                TakenE_i,
   input  logic [PC_WIDTH-1:0] PCTargetE_i,
   input  logic [GHR_BITS-1:0] ghrE_i,
`ifdef BP_STATS_EN
   input  logic                mispredictE_i,
   output logic [31:0]         branchCountE_o,
   output logic [31:0]         mispredictCountE_o
`else
   input  logic                mispredictE_i
`endif
);

   localparam int PHT_ENTRIES = 1 << PHT_BITS;

   bp_ctr_t             pht_q [PHT_ENTRIES];
   logic [GHR_BITS-1:0] ghr_q;
   logic [GHR_BITS-1:0] ghr_d;

   logic [PHT_BITS-1:0] idxF;
   logic [PHT_BITS-1:0] idxE;
   logic                phtDirF;
   logic                btbHitF;
   logic [PC_WIDTH-1:0] btbTargetF;
   logic                btbWrite;
   logic                repairE;
   logic [GHR_BITS-1:0] ghrSpec;
   logic [GHR_BITS-1:0] ghrRepair;

   // Index hashing: word-aligned PC bits XOR the zero-extended history, the
   // same hash at both ends so Execute trains the counter Fetch consulted.
   assign idxF = PCF_i[PHT_BITS+1:2] ^ PHT_BITS'(ghr_q);
   assign idxE = PCE_i[PHT_BITS+1:2] ^ PHT_BITS'(ghrE_i);

   assign phtDirF  = pht_q[idxF][1];
   assign btbWrite = BranchE_i && TakenE_i;
   assign repairE  = BranchE_i && mispredictE_i;

   bp_btb #(
      .PC_WIDTH (PC_WIDTH),
      .BTB_BITS (BTB_BITS),
      .TAG_BITS (TAG_BITS)
   ) u_btb (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rdPc_i     (PCF_i),
      .hit_o      (btbHitF),
      .target_o   (btbTargetF),
      .we_i       (btbWrite),
      .wrPc_i     (PCE_i),
      .wrTarget_i (PCTargetE_i)
   );

   // Fetch outputs: a branch the BTB does not know is always predicted
   // not taken, so the direction counter is masked by the hit.
   always_comb begin
      predictTakenF_o  = btbHitF && phtDirF;
      predictTargetF_o = btbTargetF;
      predictGhrF_o    = ghr_q;
   end

   // Shifted history candidates; a one-bit history simply holds the newest outcome.
   generate
      if (GHR_BITS == 1) begin : g_ghrOne
         assign ghrSpec   = predictTakenF_o;
         assign ghrRepair = TakenE_i;
      end else begin : g_ghrMany
         assign ghrSpec   = {ghr_q[GHR_BITS-2:0], predictTakenF_o};
         assign ghrRepair = {ghrE_i[GHR_BITS-2:0], TakenE_i};
      end
   endgenerate

   // History next state: Execute repair outranks the Fetch speculation since
   // anything fetched alongside a mispredict is on the wrong path.
   always_comb begin
      ghr_d = ghr_q;
      if (repairE) begin
         ghr_d = ghrRepair;
      end else if (fetchValidF_i && btbHitF) begin
         ghr_d = ghrSpec;
      end
   end

   // History register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   // Pattern history table: every resolved conditional branch nudges the
   // counter that was indexed with its own history snapshot.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < PHT_ENTRIES; i++) begin
            pht_q[i] <= CTR_INIT;
         end
      end else if (BranchE_i) begin
         pht_q[idxE] <= bp_sat_update(pht_q[idxE], TakenE_i);
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] branchCount_q;
   logic [31:0] mispredictCount_q;

   assign branchCountE_o     = branchCount_q;
   assign mispredictCountE_o = mispredictCount_q;

   // Statistics counters, stopping at all-ones rather than wrapping to zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         branchCount_q     <= '0;
         mispredictCount_q <= '0;
      end else begin
         if (BranchE_i && (branchCount_q != 32'hFFFF_FFFF)) begin
            branchCount_q <= branchCount_q + 32'd1;
         end
         if (repairE && (mispredictCount_q != 32'hFFFF_FFFF)) begin
            mispredictCount_q <= mispredictCount_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_predict_gshare.sv
// Testbench for branch_predict_gshare with default parameters.
// A table of single-cycle steps drives Fetch and Execute together and checks
// the Fetch outputs just before each clock edge; hand-written sequences then
// cover asynchronous reset and (with BP_STATS_EN) the statistics counters.
module tb_branch_predict_gshare;

   logic        clk;
   logic        rst;
   logic [31:0] pcF;
   logic        fetchValid;
   logic        predTaken;
   logic [31:0] predTarget;
   logic [7:0]  predGhr;
   logic [31:0] pcE;
   logic        branchE;
   logic        takenE;
   logic [31:0] targetE;
   logic [7:0]  ghrE;
   logic        mispE;
`ifdef BP_STATS_EN
   logic [31:0] branchCount;
   logic [31:0] mispCount;
`endif

   int testsRun;
   int testsFailed;

   typedef struct {
      logic        br;
      logic        tk;
      logic        misp;
      logic [31:0] pce;
      logic [31:0] tgt;
      logic [7:0]  ghre;
      logic        fv;
      logic [31:0] pcf;
      logic        expTaken;
      logic [31:0] expTarget;
      logic [7:0]  expGhr;
   } vec_t;

   localparam int NVEC = 25;
   vec_t vecs [NVEC];

   branch_predict_gshare dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .PCF_i            (pcF),
      .fetchValidF_i    (fetchValid),
      .predictTakenF_o  (predTaken),
      .predictTargetF_o (predTarget),
      .predictGhrF_o    (predGhr),
      .PCE_i            (pcE),
      .BranchE_i        (branchE),
      .TakenE_i         (takenE),
      .PCTargetE_i      (targetE),
      .ghrE_i           (ghrE),
`ifdef BP_STATS_EN
      .mispredictE_i      (mispE),
      .branchCountE_o     (branchCount),
      .mispredictCountE_o (mispCount)
`else
      .mispredictE_i    (mispE)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic br, input logic tk, input logic misp,
                               input logic [31:0] pce, input logic [31:0] tgt,
                               input logic [7:0] ghre, input logic fv,
                               input logic [31:0] pcf, input logic expTaken,
                               input logic [31:0] expTarget, input logic [7:0] expGhr);
      vec_t v;
      v.br = br; v.tk = tk; v.misp = misp; v.pce = pce; v.tgt = tgt;
      v.ghre = ghre; v.fv = fv; v.pcf = pcf; v.expTaken = expTaken;
      v.expTarget = expTarget; v.expGhr = expGhr;
      return v;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic expTaken,
                              input logic [31:0] expTarget, input logic [7:0] expGhr);
      checkValue({name, ".taken"},  {31'd0, predTaken}, {31'd0, expTaken});
      checkValue({name, ".target"}, predTarget, expTarget);
      checkValue({name, ".ghr"},    {24'd0, predGhr}, {24'd0, expGhr});
   endtask

   // Drive one step at the falling edge; outputs are checked before the
   // following rising edge commits the step's training and history update.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      branchE    = v.br;
      takenE     = v.tk;
      mispE      = v.misp;
      pcE        = v.pce;
      targetE    = v.tgt;
      ghrE       = v.ghre;
      fetchValid = v.fv;
      pcF        = v.pcf;
      #1;
   endtask

   task automatic idleInputs();
      branchE    = 1'b0;
      takenE     = 1'b0;
      mispE      = 1'b0;
      pcE        = 32'h0;
      targetE    = 32'h0;
      ghrE       = 8'h0;
      fetchValid = 1'b0;
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst         = 1'b1;
      pcF         = 32'h100;
      idleInputs();

      //       br tk mp  PCE      target   ghrE   fv PCF      expTk expTarget expGhr
      vecs[0]  = mk(0, 0, 0, 32'h000, 32'h000, 8'h00, 0, 32'h100, 0, 32'h000, 8'h00);
      vecs[1]  = mk(1, 1, 0, 32'h100, 32'h200, 8'h00, 0, 32'h100, 0, 32'h000, 8'h00);
      vecs[2]  = mk(1, 1, 0, 32'h100, 32'h200, 8'h00, 0, 32'h100, 1, 32'h200, 8'h00);
      vecs[3]  = mk(0, 0, 0, 32'h000, 32'h000, 8'h00, 0, 32'h100, 1, 32'h200, 8'h00);
      vecs[4]  = mk(0, 0, 0, 32'h000, 32'h000, 8'h00, 0, 32'h200, 0, 32'h000, 8'h00);
      vecs[5]  = mk(1, 1, 0, 32'h100, 32'h200, 8'h01, 0, 32'h100, 1, 32'h200, 8'h00);
      vecs[6]  = mk(1, 1, 0, 32'h100, 32'h200, 8'h01, 0, 32'h100, 1, 32'h200, 8'h00);
      vecs[7]  = mk(1, 1, 0, 32'h100, 32'h200, 8'h03, 0, 32'h100, 1, 32'h200, 8'h00);
      vecs[8]  = mk(1, 1, 0, 32'h100, 32'h200, 8'h03, 0, 32'h100, 1, 32'h200, 8'h00);
      vecs[9]  = mk(0, 0, 0, 32'h000, 32'h000, 8'h00, 1, 32'h100, 1, 32'h200, 8'h00);
      vecs[10] = mk(0, 0, 0, 32'h000, 32'h000, 8'h00, 1, 32'h100, 1, 32'h200, 8'h01);
      vecs[11] = mk(0, 0, 0, 32'h000, 32'h000, 8'h00, 1, 32'h100, 1, 32'h200, 8'h03);
      vecs[12] = mk(0, 0, 0, 32'h000, 32'h000, 8'h00, 0, 32'h100, 0, 32'h200, 8'h07);
      vecs[13] = mk(1, 0, 1, 32'h300, 32'h000, 8'h01, 1, 32'h100, 0, 32'h200, 8'h07);
      vecs[14] = mk(0, 0, 0, 32'h000, 32'h000, 8'h00, 0, 32'h100, 0, 32'h200, 8'h02);
      vecs[15] = mk(1, 1, 0, 32'h110, 32'h340, 8'h80, 0, 32'h110, 0, 32'h000, 8'h02);
      vecs[16] = mk(1, 0, 0, 32'h110, 32'h7FC, 8'h02, 0, 32'h110, 0, 32'h340, 8'h02);
      vecs[17] = mk(1, 0, 0, 32'h110, 32'h7FC, 8'h02, 0, 32'h110, 0, 32'h340, 8'h02);
      vecs[18] = mk(1, 0, 0, 32'h110, 32'h7FC, 8'h02, 0, 32'h110, 0, 32'h340, 8'h02);
      vecs[19] = mk(1, 0, 0, 32'h110, 32'h7FC, 8'h02, 0, 32'h110, 0, 32'h340, 8'h02);
      vecs[20] = mk(1, 1, 0, 32'h110, 32'h340, 8'h02, 0, 32'h110, 0, 32'h340, 8'h02);
      vecs[21] = mk(1, 1, 0, 32'h110, 32'h340, 8'h02, 0, 32'h110, 0, 32'h340, 8'h02);
      vecs[22] = mk(0, 0, 0, 32'h000, 32'h000, 8'h00, 0, 32'h110, 1, 32'h340, 8'h02);
      vecs[23] = mk(0, 1, 1, 32'h110, 32'h000, 8'h55, 0, 32'h110, 1, 32'h340, 8'h02);
      vecs[24] = mk(0, 0, 0, 32'h000, 32'h000, 8'h00, 0, 32'h110, 1, 32'h340, 8'h02);

      // Outputs while reset is held.
      #12;
      checkOutput("inReset", 1'b0, 32'h0, 8'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i), vecs[i].expTaken, vecs[i].expTarget, vecs[i].expGhr);
      end

      // Reset mid-operation: a known hit must vanish without a clock edge.
      @(negedge clk);
      idleInputs();
      pcF = 32'h110;
      #1;
      checkOutput("preMidReset", 1'b1, 32'h340, 8'h02);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midResetAsync", 1'b0, 32'h0, 8'h0);

      // Training presented across an edge while reset is held is dropped.
      @(negedge clk);
      branchE = 1'b1;
      takenE  = 1'b1;
      pcE     = 32'h100;
      targetE = 32'h200;
      mispE   = 1'b1;
      ghrE    = 8'h0F;
      @(negedge clk);
      idleInputs();
      rst = 1'b0;
      pcF = 32'h100;
      #1;
      checkOutput("afterReset100", 1'b0, 32'h0, 8'h0);
      pcF = 32'h110;
      #1;
      checkOutput("afterReset110", 1'b0, 32'h0, 8'h0);

`ifdef BP_STATS_EN
      // Five branches, two of them mispredicted.
      checkValue("statsBranchReset", branchCount, 32'd0);
      checkValue("statsMispReset",   mispCount,   32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         branchE = 1'b1;
         takenE  = 1'b0;
         pcE     = 32'h500;
         ghrE    = 8'h00;
         mispE   = (i == 0 || i == 2);
      end
      @(negedge clk);
      idleInputs();
      #1;
      checkValue("statsBranch", branchCount, 32'd5);
      checkValue("statsMisp",   mispCount,   32'd2);
      #2;
      rst = 1'b1;
      #1;
      checkValue("statsBranchAsyncClr", branchCount, 32'd0);
      checkValue("statsMispAsyncClr",   mispCount,   32'd0);
      @(negedge clk);
      rst = 1'b0;
`endif

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
